// File: rtl/mul_pkg.sv
// mul_pkg: shared widths, iteration count and FSM state type for the iterative multiplier
package mul_pkg;
    localparam int MUL_WIDTH = 16;
    localparam int MUL_CYCLES = 16;
    localparam int PRODUCT_WIDTH = 32;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/FullAdder16b.sv
// FullAdder16b: 16-bit adder with carry in/out for the shift-add partial product
module FullAdder16b
    import mul_pkg::*;
(
    input  logic [MUL_WIDTH-1:0] a,
    input  logic [MUL_WIDTH-1:0] b,
    input  logic                 carry_in,
    output logic [MUL_WIDTH-1:0] sum,
    output logic                 carry_out
);
    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + (MUL_WIDTH + 1)'(carry_in);
endmodule

// File: rtl/mul_iter16.sv
// mul_iter16: 16x16 shift-add multiplier, one bit per cycle; optional signed mode via MUL_SIGNED_EN
module mul_iter16
    import mul_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     start_in,
    input  logic [MUL_WIDTH-1:0]     operand1_in,
    input  logic [MUL_WIDTH-1:0]     operand2_in,
`ifdef MUL_SIGNED_EN
    input  logic                     signed_in,
`endif
    output logic                     ready_out,
    output logic                     busy_out,
    output logic                     valid_out,
    output logic [PRODUCT_WIDTH-1:0] product_out
);
    state_t state, next_state;
    logic [4:0] count;
    // {hi, lo}; the add carry lands in hi[15] on the shift, so the top bit is always zero and not stored
    logic [PRODUCT_WIDTH-1:0] acc;
    logic [MUL_WIDTH-1:0] mcand, op1, op2, add_sum;
    logic add_carry, accept, zero_op, last;
    logic [MUL_WIDTH:0] hi_next;
    logic [PRODUCT_WIDTH-1:0] shifted, result;

    assign ready_out = state == IDLE;
    assign busy_out = state != IDLE;
    assign valid_out = state == DONE;
    assign accept = start_in && ready_out;
    assign zero_op = EARLY_EXIT && (operand1_in == '0 || operand2_in == '0);
    assign last = count == 5'(MUL_CYCLES - 1);

    FullAdder16b u_add (
        .a(acc[PRODUCT_WIDTH-1:MUL_WIDTH]),
        .b(mcand),
        .carry_in(1'b0),
        .sum(add_sum),
        .carry_out(add_carry)
    );

    assign hi_next = acc[0] ? {add_carry, add_sum} : {1'b0, acc[PRODUCT_WIDTH-1:MUL_WIDTH]};
    assign shifted = {hi_next, acc[MUL_WIDTH-1:1]};

`ifdef MUL_SIGNED_EN
    logic negate;
    assign op1 = (signed_in && operand1_in[MUL_WIDTH-1]) ? -operand1_in : operand1_in;
    assign op2 = (signed_in && operand2_in[MUL_WIDTH-1]) ? -operand2_in : operand2_in;
    assign result = negate ? -shifted : shifted;
    // Product sign, captured with the operands so the magnitude result can be fixed up on DONE entry
    always_ff @(posedge clk_in) begin
        negate <= rst_in ? 1'b0 : accept ? signed_in && (operand1_in[MUL_WIDTH-1] ^ operand2_in[MUL_WIDTH-1]) : negate;
    end
`else
    assign op1 = operand1_in;
    assign op2 = operand2_in;
    assign result = shifted;
`endif

    // State register
    always_ff @(posedge clk_in) begin
        state <= rst_in ? IDLE : next_state;
    end

    // Next state: zero operands skip straight to DONE when early exit is enabled
    always_comb begin
        next_state = state;
        if (state == IDLE && accept)
            next_state = zero_op ? DONE : CALC;
        else if (state == CALC && last)
            next_state = DONE;
        else if (state == DONE)
            next_state = IDLE;
    end

    // Datapath: load on accept, one add-shift step per CALC cycle, publish product on DONE entry
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            acc <= '0;
            mcand <= '0;
            count <= '0;
            product_out <= '0;
        end else if (accept) begin
            acc <= {{MUL_WIDTH{1'b0}}, op2};
            mcand <= op1;
            count <= '0;
            if (zero_op)
                product_out <= '0;
        end else if (state == CALC) begin
            acc <= shifted;
            count <= count + 5'd1;
            if (last)
                product_out <= result;
        end
    end
endmodule
